// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Imported by the arbiter top and its round-robin picker.
package uart_arb_pkg;

  localparam int N_REQ_DEF   = 2;
  localparam int DATA_W_DEF  = 8;
  localparam int BUSY_TO_DEF = 4;

  localparam int ST_W    = 2;
  localparam int MAX_REQ = 8;
  localparam int MAX_IW  = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE,
    LAUNCH,
    WAIT_RISE,
    WAIT_FALL
  } state_e;

  function automatic logic [MAX_IW-1:0] oh2idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// Round-robin winner select: first masked request after the pointer.
// Doubling the vector turns wrap-around into a plain low-bit search.
module rr_priority_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0]   req_m;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  always_comb begin
    req_m   = i_req & i_mask;
    dbl     = {req_m, req_m};
    rot     = N'(dbl >> (32'(i_ptr) + 32'd1));
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        o_valid = 1'b1;
        o_idx   = IW'((32'(i_ptr) + 32'd1 + 32'(i)) % 32'(N));
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte sources with
// round-robin arbitration, message lock and send/busy sequencing.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic [N_REQ-1:0]        o_grant,
  input  logic                    i_tx_busy,
  output logic                    o_tx_send,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_active,
  output logic                    o_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TO + 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               send_q, send_d;
  logic               active_q, active_d;
  logic               to_q, to_d;
  logic               lock_q, lock_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      cnt_inc;

  logic               lock_hold;
  logic [N_REQ-1:0]   pick_mask;
  logic [IW-1:0]      win;
  logic               win_v;

  // While the owner keeps its lock, only the owner may win.
  assign lock_hold = lock_q & (|(i_lock & grant_q));
  assign pick_mask = lock_hold ? grant_q : '1;

  rr_priority_pick #(
    .N (N_REQ)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (rr_q),
    .i_mask  (pick_mask),
    .o_idx   (win),
    .o_valid (win_v)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    send_d  = 1'b0;
    to_d    = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        if (!i_tx_busy) begin
          if (lock_q && !lock_hold) lock_d = 1'b0;
          if (win_v) begin
            data_d       = i_data[32'(win)*DATA_W +: DATA_W];
            grant_d      = '0;
            grant_d[win] = 1'b1;
            ack_d        = grant_d;
            rr_d         = win;
            send_d       = 1'b1;
            state_d      = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        lock_d  = |(i_lock & grant_q);
        cnt_d   = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (i_tx_busy) begin
          state_d = WAIT_FALL;
        end else begin
          cnt_d = cnt_inc;
          // Give up and treat the byte as sent; Serial never started.
          if (cnt_inc == CW'(BUSY_TO - 1)) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_FALL: begin
        if (!i_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      rr_q     <= IW'(N_REQ - 1);
      grant_q  <= '0;
      ack_q    <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      active_q <= 1'b0;
      to_q     <= 1'b0;
      lock_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      send_q   <= send_d;
      active_q <= active_d;
      to_q     <= to_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_ack     = ack_q;
  assign o_grant   = grant_q;
  assign o_tx_send = send_q;
  assign o_tx_data = data_q;
  assign o_active  = active_q;
  assign o_timeout = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple Serial busy model.
// Stimulus queues expected bytes; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  lock = '0;
  logic [15:0] data = '0;
  logic [1:0]  ack;
  logic [1:0]  grant;
  logic        busy;
  logic        send;
  logic [7:0]  txd;
  logic        active;
  logic        tout;

  uart_tx_arbiter #(
    .N_REQ   (2),
    .DATA_W  (8),
    .BUSY_TO (4)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_req     (req),
    .i_lock    (lock),
    .i_data    (data),
    .o_ack     (ack),
    .o_grant   (grant),
    .i_tx_busy (busy),
    .o_tx_send (send),
    .o_tx_data (txd),
    .o_active  (active),
    .o_timeout (tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int to_cnt = 0;
  int last_send_cyc = -1;
  int last_to_cyc = -1;
  logic [1:0] prev_ack = '0;
  logic prev_to = 1'b0;

  // Serial model: busy for busy_len cycles after each send pulse.
  int busy_cnt = 0;
  int busy_len = 10;
  bit model_en = 1'b1;
  bit force_busy = 1'b0;

  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else if (send && model_en) busy_cnt <= busy_len;
  end
  assign busy = force_busy | (busy_cnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ack != 2'b00 && !send) begin
        checks++; errors++;
        $display("FAIL ack_no_send: ack=%b send=%b", ack, send);
      end
      if (ack != 2'b00 && prev_ack != 2'b00) begin
        checks++; errors++;
        $display("FAIL ack_width: ack=%b prev=%b", ack, prev_ack);
      end
      if (tout && prev_to) begin
        checks++; errors++;
        $display("FAIL timeout_width: two cycles high");
      end
      if (send) begin
        ack_cnt++;
        last_send_cyc = cyc;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_send: data=%0h grant=%b", txd, grant);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tx_data", 32'(txd), 32'(e.d));
          check("grant", 32'(grant), 32'(e.g));
          check("ack", 32'(ack), 32'(e.g));
          check("active_send", 32'(active), 32'd1);
        end
      end
      if (tout) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
    end
    prev_ack = ack;
    prev_to  = tout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (ack_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_ack: got %0d acks expected %0d", ack_cnt, target);
    end
  endtask

  task automatic wait_to(input int target, input int budget);
    int n = 0;
    while (to_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (to_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_timeout: got %0d expected %0d", to_cnt, target);
    end
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      tick();
      n++;
    end
    if (!busy) begin
      checks++; errors++;
      $display("FAIL wait_busy: busy never rose");
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (active && n < budget) begin
      tick();
      n++;
    end
    if (active) begin
      checks++; errors++;
      $display("FAIL wait_idle: still active");
    end
  endtask

  initial begin
    int c;
    int b;

    // Reset state
    repeat (3) tick();
    check("rst_send", 32'(send), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_active", 32'(active), 0);
    check("rst_timeout", 32'(tout), 0);
    check("rst_data", 32'(txd), 0);
    rst = 1'b0;
    tick();

    // Round robin with both requesters held
    data = 16'h4241;
    req  = 2'b11;
    c    = cyc;
    push(2'b01, 8'h41);
    push(2'b10, 8'h42);
    push(2'b01, 8'h41);
    push(2'b10, 8'h42);
    wait_ack(1, 20);
    check("first_latency", 32'(last_send_cyc), 32'(c + 1));
    wait_ack(4, 200);
    req = 2'b00;
    wait_idle(40);
    check("no_timeout_rr", 32'(to_cnt), 0);

    // Locked three-byte message from requester 1
    b    = ack_cnt;
    data = 16'h4F30;
    lock = 2'b10;
    req  = 2'b10;
    push(2'b10, 8'h4F);
    push(2'b10, 8'h4B);
    push(2'b10, 8'h0A);
    push(2'b01, 8'h30);
    wait_ack(b + 1, 40);
    data[15:8] = 8'h4B;
    req = 2'b11;
    wait_ack(b + 2, 40);
    data[15:8] = 8'h0A;
    wait_ack(b + 3, 40);
    req  = 2'b01;
    lock = 2'b00;
    data[15:8] = 8'hEE;
    wait_ack(b + 4, 40);
    req = 2'b00;
    data[7:0] = 8'hEE;
    wait_idle(40);

    // Busy never rises: timeout
    model_en  = 1'b0;
    b         = ack_cnt;
    data[7:0] = 8'h55;
    req       = 2'b01;
    push(2'b01, 8'h55);
    wait_ack(b + 1, 20);
    req = 2'b00;
    wait_to(1, 20);
    check("timeout_delay", 32'(last_to_cyc - last_send_cyc), 32'd4);
    check("idle_after_to", 32'(active), 0);
    model_en   = 1'b1;
    data[15:8] = 8'h66;
    req        = 2'b10;
    push(2'b10, 8'h66);
    wait_ack(b + 2, 20);
    req = 2'b00;
    wait_idle(40);
    check("single_timeout", 32'(to_cnt), 32'd1);

    // Request withdrawn during WAIT_FALL
    b         = ack_cnt;
    data[7:0] = 8'h11;
    req       = 2'b01;
    push(2'b01, 8'h11);
    wait_ack(b + 1, 20);
    wait_busy(10);
    tick();
    req = 2'b00;
    repeat (25) tick();
    check("withdraw_acks", 32'(ack_cnt), 32'(b + 1));
    check("withdraw_grant_idx", 32'(oh2idx(8'(grant))), 0);
    check("withdraw_grant", 32'(grant), 32'b01);
    check("withdraw_active", 32'(active), 0);

    // Reset in WAIT_FALL, then requester 0 first
    b    = ack_cnt;
    data = 16'h4241;
    req  = 2'b11;
    push(2'b10, 8'h42);
    wait_ack(b + 1, 20);
    wait_busy(10);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_data", 32'(txd), 0);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_send", 32'(send), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    b   = ack_cnt;
    push(2'b01, 8'h41);
    wait_ack(b + 1, 40);
    req = 2'b00;
    wait_idle(40);

    // Serial busy out of reset holds off the first grant
    rst        = 1'b1;
    force_busy = 1'b1;
    tick();
    rst       = 1'b0;
    b         = ack_cnt;
    data[7:0] = 8'h77;
    req       = 2'b01;
    push(2'b01, 8'h77);
    repeat (6) tick();
    check("busy_hold_acks", 32'(ack_cnt), 32'(b));
    check("busy_hold_grant", 32'(grant), 0);
    force_busy = 1'b0;
    c = cyc;
    wait_ack(b + 1, 20);
    check("busy_fall_latency", 32'(last_send_cyc), 32'(c + 1));
    req = 2'b00;
    wait_idle(40);

    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single Serial UART transmitter between N_REQ byte sources, e.g. string_transmitter (req 0) and a memory-dump streamer (req 1).
- Arbitration is round-robin, with an optional per-requester lock so a multi-byte message is not interleaved with other traffic.
- Sequences the UART send/busy handshake: one send pulse per byte, then waits for the busy pulse to complete.
- Sits between the byte producers and Serial's i_send_data_to_host_computer / i_send_data / o_busy.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width.
- BUSY_TO, 4, max cycles to wait for i_tx_busy to rise after a send pulse.

Ports:
- i_Clk  input  1  system clock (CLOCK_50).
- i_Rst  input  1  asynchronous, active-high reset.
- i_req  input  N_REQ  per-requester request; hold high with data stable until ack.
- i_lock  input  N_REQ  keep grant after this byte (message continues).
- i_data  input  N_REQ*DATA_W  requester n data on bits [n*DATA_W +: DATA_W].
- o_ack  output  N_REQ  one-cycle pulse: byte from requester n accepted.
- o_grant  output  N_REQ  one-hot current/last owner; 0 when unowned.
- i_tx_busy  input  1  Serial o_busy.
- o_tx_send  output  1  one-cycle send pulse to Serial.
- o_tx_data  output  DATA_W  byte to Serial; registered, stable from send until the return to IDLE.
- o_active  output  1  high in any state except IDLE.
- o_timeout  output  1  one-cycle pulse when BUSY_TO expires.

Behaviour:
Reset (async, any state):
- State=IDLE; all outputs 0; lock_valid=0.
- rr_ptr=N_REQ-1, so requester 0 has first priority.
- Busy-wait counter cleared.

States:
- IDLE: evaluate only when i_tx_busy=0.
  - If lock_valid and i_lock[owner]=1: candidate set is {owner}; other requesters wait, even if the owner's i_req is low.
  - If lock_valid and i_lock[owner]=0: lock_valid clears this cycle; normal round-robin applies in the same cycle.
  - Round-robin: winner is the first set i_req scanning from rr_ptr+1 with wrap-around.
  - On a winner w: latch o_tx_data=i_data[w]; o_grant=onehot(w); rr_ptr=w → LAUNCH.
  - No request, or i_tx_busy=1: stay in IDLE; o_grant holds its last value.
- LAUNCH (1 cycle):
  - o_tx_send=1 and o_ack[w]=1.
  - lock_valid=i_lock[w], sampled this cycle.
  - Counter cleared → WAIT_RISE.
- WAIT_RISE:
  - i_tx_busy=1 → WAIT_FALL.
  - Otherwise counter++; when counter reaches BUSY_TO-1 without busy, pulse o_timeout → IDLE (the byte counts as sent, no retry).
- WAIT_FALL:
  - i_tx_busy=0 → IDLE.

Timing and rules:
- Latency: i_req high in an IDLE cycle with busy low → o_tx_send and o_ack on the next cycle.
- Minimum byte period is 4 cycles plus the UART busy time.
- A requester may present its next byte in the cycle after ack. Requests are sampled only in IDLE, so a held i_req is never double-accepted.
- Dropping i_req before ack withdraws the request without error; the winner is re-evaluated in each IDLE cycle.
- Simultaneous requests resolve strictly by rr_ptr order. After w is served, w has the lowest priority unless locked.
- i_tx_busy already high in IDLE (e.g. Serial still busy after reset): no grant until it falls.
- i_tx_busy rising in the same cycle as LAUNCH: ignored; WAIT_RISE sees it on the following cycle.
- Changes to i_data after ack do not affect o_tx_data.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, LAUNCH, WAIT_RISE, WAIT_FALL), state width constant, default N_REQ/DATA_W/BUSY_TO constants, and a onehot-to-index function.
- Sub-module rr_priority_pick (combinational):
  - Inputs: request vector, pointer, lock mask.
  - Outputs: winner index and a valid flag.
  - Implemented as a doubled-vector masked priority encoder.
- The top level holds the FSM, data register, lock and counter.

Test Plan:
- Reset mid-WAIT_FALL with i_Rst=1 for 1 cycle → all outputs 0 the same cycle; after release, req=2'b11 grants requester 0 first (rr_ptr=1).
- req=2'b11 held continuously, i_data=0x41 / 0x42, Serial model busy for 10 cycles → o_tx_data sequence 0x41, 0x42, 0x41, 0x42; each o_ack is a single cycle; o_tx_send one cycle after the IDLE evaluation.
- Requester 1 sends "OK\n" (0x4F, 0x4B, 0x0A) with i_lock=1 on the first two bytes while req0 is also high → three consecutive requester-1 bytes, then requester 0 is served.
- Busy model never rises, BUSY_TO=4 → o_timeout pulses exactly 4 cycles after o_tx_send; back to IDLE; next request served normally.
- i_tx_busy held high at start with req=2'b01 → no o_tx_send until busy falls; send pulse one cycle after the fall.
- i_req[0] dropped while the FSM is in WAIT_FALL, before its second byte → no o_ack[0]; o_grant stays at its last value; no spurious o_tx_send.
